// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: message width, default check degree,
// the saturating magnitude helper and the check node unit state encoding.
package ldpc_pkg;

    localparam int MSG_W  = 32;
    localparam int CNU_DC = 6;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } cnu_state_e;

    // |v| in MSG_W-1 bits; the most negative value saturates to all ones.
    function automatic logic [MSG_W-2:0] sat_mag(input logic [MSG_W-1:0] v);
        logic [MSG_W-1:0] neg;
        if (!v[MSG_W-1]) return v[MSG_W-2:0];
        neg = -v;
        if (neg[MSG_W-1]) return {(MSG_W-1){1'b1}};
        return neg[MSG_W-2:0];
    endfunction

endpackage

// File: rtl/cnu_min_tracker.sv
// Two-minimum tracker for the serial check node: keeps min1, min2 and the
// edge index of min1, with an init strobe and a per-edge update strobe.
module cnu_min_tracker
    import ldpc_pkg::*;
#(
    parameter int MW = MSG_W - 1,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          upd,
    input  logic          first,
    input  logic [MW-1:0] mag,
    input  logic [IW-1:0] cnt,
    output logic [MW-1:0] min1,
    output logic [MW-1:0] min2,
    output logic [IW-1:0] idx
);

    localparam logic [MW-1:0] MAG_MAX = '1;

    logic [MW-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [MW-1:0] base1, base2;
    logic [IW-1:0] base_idx;

    // The first edge of a check compares against a fresh tracker, so a check
    // started straight out of reset (registers at 0) is still correct.
    always_comb begin
        base1    = first ? MAG_MAX : min1_q;
        base2    = first ? MAG_MAX : min2_q;
        base_idx = first ? '0 : idx_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        idx_d    = idx_q;
        if (init) begin
            min1_d = MAG_MAX;
            min2_d = MAG_MAX;
            idx_d  = '0;
        end else if (upd) begin
            min1_d = base1;
            min2_d = base2;
            idx_d  = base_idx;
            if (mag < base1) begin
                min2_d = base1;
                min1_d = mag;
                idx_d  = cnt;
            end else if (mag < base2) begin
                min2_d = mag;
            end
        end
    end

    // NOTE: async reset in the sensitivity list, and <= for every register so
    // all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min1_q <= '0;
            min2_q <= '0;
            idx_q  <= '0;
        end else begin
            min1_q <= min1_d;
            min2_q <= min2_d;
            idx_q  <= idx_d;
        end
    end

    assign min1 = min1_q;
    assign min2 = min2_q;
    assign idx  = idx_q;

endmodule

// File: rtl/cnu_minsum_serial.sv
// Serial min-sum check node unit: accepts DC Q messages, then emits DC R messages.
// Define CNU_OFFSET_EN for offset min-sum (OFFSET subtracted from both minima). W <= MSG_W.
module cnu_minsum_serial
    import ldpc_pkg::*;
#(
    parameter int W      = MSG_W,
    parameter int DC     = CNU_DC,
    parameter int OFFSET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  q_valid,
    output logic                  q_ready,
    input  logic [W-1:0]          q_in,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [W-1:0]          r_out,
    output logic [$clog2(DC)-1:0] r_idx,
    output logic                  r_last,
    output logic                  parity
);

    localparam int IW = $clog2(DC);
    localparam logic [W-2:0] MAG_MAX = '1;
`ifdef CNU_OFFSET_EN
    localparam logic OFFSET_ON = 1'b1;
`else
    localparam logic OFFSET_ON = 1'b0;
`endif
    localparam logic [W-2:0] OFF_AMT = (W-1)'(OFFSET) & {(W-1){OFFSET_ON}};

    cnu_state_e    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [DC-1:0] sign_q, sign_d;
    logic          parity_q, parity_d;

    logic          cnt_last, q_acc, r_acc;
    logic [MSG_W-1:0] q_ext;
    logic [MSG_W-2:0] mag_full;
    logic [W-2:0]  q_mag;
    logic [W-2:0]  min1, min2, sel_mag, adj_mag;
    logic [IW-1:0] min_idx;
    logic [W-1:0]  r_mag;
    logic          r_sign;

    assign cnt_last = (cnt_q == IW'(DC - 1));
    assign q_acc    = (state_q == ACCUM) && q_valid;
    assign r_acc    = (state_q == EMIT) && r_ready;

    assign q_ext    = MSG_W'($signed(q_in));
    assign mag_full = sat_mag(q_ext);
    assign q_mag    = (mag_full > (MSG_W-1)'(MAG_MAX)) ? MAG_MAX : mag_full[W-2:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        parity_d = parity_q;
        case (state_q)
            ACCUM: begin
                if (q_valid) begin
                    sign_d[cnt_q] = q_in[W-1];
                    parity_d      = ((cnt_q == '0) ? 1'b0 : parity_q) ^ q_in[W-1];
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (r_ready) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ACCUM;
            cnt_q    <= '0;
            sign_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            parity_q <= parity_d;
        end
    end

    cnu_min_tracker #(
        .MW (W - 1),
        .IW (IW)
    ) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .init  (r_acc && cnt_last),
        .upd   (q_acc),
        .first (cnt_q == '0),
        .mag   (q_mag),
        .cnt   (cnt_q),
        .min1  (min1),
        .min2  (min2),
        .idx   (min_idx)
    );

    // Output mux; a zero magnitude is never negated, so no negative zero.
    always_comb begin
        sel_mag = (cnt_q == min_idx) ? min2 : min1;
        adj_mag = (sel_mag > OFF_AMT) ? (sel_mag - OFF_AMT) : '0;
        r_sign  = parity_q ^ sign_q[cnt_q];
        r_mag   = {1'b0, adj_mag};
        r_out   = '0;
        if (state_q == EMIT) r_out = (r_sign && (adj_mag != '0)) ? -r_mag : r_mag;
    end

    assign q_ready = (state_q == ACCUM);
    assign r_valid = (state_q == EMIT);
    assign r_idx   = r_valid ? cnt_q : '0;
    assign r_last  = r_valid && cnt_last;
    assign parity  = r_valid && parity_q;

endmodule
